ipml_prefetch_rd_ctrl_v2_0: RTL and testbench

- Read-side prefetch engine for the ipml FIFO family.
- Sits between the FIFO control/SDPRAM read port and the user, converting the RAM's registered read into a first-word-fall-through valid/ready stream.
- Generalises the fixed depth-2 register FIFO:
  - prefetch depth is parameterised;
  - RAM read latency 1 or 2 (RAM output register) is supported;
  - a credit check prevents overrun;
  - the buffer fill level is exported.

---
 rtl/ipml_prefetch_pkg.sv | 14 +
 rtl/ipml_prefetch_buf.sv | 43 ++++
 rtl/ipml_prefetch_rd_ctrl_v2_0.sv | 67 ++++++
 tb/tb_ipml_prefetch_rd_ctrl_v2_0.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_prefetch_pkg.sv
// ipml_prefetch_pkg: shared constants and helpers for the ipml read-side prefetch engine
package ipml_prefetch_pkg;
  localparam int PF_DEPTH_MAX = 8;
  localparam int RAM_LAT_MAX = 2;
  localparam int PF_ERR_OVF = 0;
  localparam int PF_ERR_UNDR = 1;
  // ceil(log2(v)), minimum 1 so it can size a vector directly
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ipml_prefetch_buf.sv
// ipml_prefetch_buf: circular register buffer holding prefetched words, head exposed on rdata
module ipml_prefetch_buf
  import ipml_prefetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter int LVL_W = 2
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LVL_W-1:0]  level
);
  localparam int PW = clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_push, do_pop;
  // a pop on an empty buffer is ignored; a push into a full buffer only lands if a slot frees this cycle
  assign do_pop = pop & (level != '0);
  assign do_push = push & ((level != LVL_W'(DEPTH)) | do_pop);
  assign rdata = mem[rptr];
  // pointers wrap at DEPTH-1 so non-power-of-two depths work
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // storage, pointer and fill-level update; reset clears contents so dout reads 0
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wptr] <= wdata;
      if (do_push) wptr <= nxt(wptr);
      if (do_pop) rptr <= nxt(rptr);
      level <= (do_push & ~do_pop) ? level + 1'b1 : (do_pop & ~do_push) ? level - 1'b1 : level;
    end
  end
endmodule

// File: rtl/ipml_prefetch_rd_ctrl_v2_0.sv
// ipml_prefetch_rd_ctrl_v2_0: credit-checked SDPRAM read prefetch to FWFT stream; IPML_PREFETCH_ERR_CHK_EN adds pf_err
module ipml_prefetch_rd_ctrl_v2_0
  import ipml_prefetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PF_DEPTH = 2,
  parameter int RAM_LAT = 1,
  localparam int LVL_W = clog2(PF_DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ram_empty,
  output logic              ram_rd_en,
  output logic              ram_oce,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [LVL_W-1:0]  pf_level
`ifdef IPML_PREFETCH_ERR_CHK_EN
  , output logic [1:0]      pf_err
`endif
);
  localparam int TW = LVL_W + 1;
  localparam int IW = clog2(RAM_LAT_MAX + 1);
  logic [RAM_LAT-1:0] vld;
  logic [IW-1:0] inflight;
  logic [TW-1:0] total, need;
  logic pop, push;
  assign pop = dout_valid & dout_ready;
  assign push = vld[RAM_LAT-1];
  assign dout_valid = (pf_level != '0);
  assign inflight = IW'($countones(vld));
  assign total = TW'(pf_level) + TW'(inflight);
  assign need = total - TW'(pop);
  // issue only when a slot is guaranteed for every word already requested; pop frees one this cycle
  assign ram_rd_en = ~ram_empty & ~rd_rst & (need < TW'(PF_DEPTH));
  assign ram_oce = (RAM_LAT == 2) ? vld[0] : 1'b0;
  // in-flight shift pipe: a bit enters on issue and reaches the top when read data is valid
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) vld <= '0;
    else vld <= (vld << 1) | RAM_LAT'(ram_rd_en);
  end
  ipml_prefetch_buf #(
    .DATA_W(DATA_W),
    .DEPTH (PF_DEPTH),
    .LVL_W (LVL_W)
  ) u_buf (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .push  (push),
    .pop   (pop),
    .wdata (ram_rd_data),
    .rdata (dout),
    .level (pf_level)
  );
`ifdef IPML_PREFETCH_ERR_CHK_EN
  // sticky error flags: overflow on push into a full buffer without pop, underrun on ready with nothing valid
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) pf_err <= 2'b00;
    else begin
      pf_err[PF_ERR_OVF] <= pf_err[PF_ERR_OVF] | (push & (pf_level == LVL_W'(PF_DEPTH)) & ~pop);
      pf_err[PF_ERR_UNDR] <= pf_err[PF_ERR_UNDR] | (dout_ready & ~dout_valid);
    end
  end
`endif
endmodule

// File: tb/tb_ipml_prefetch_rd_ctrl_v2_0.sv
// tb_ipml_prefetch_rd_ctrl_v2_0: three configurations (2/1, 3/2, 4/2) checked against a word-count reference model
module tb_ipml_prefetch_rd_ctrl_v2_0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] empty, ready, rd_en, oce, dv;
  logic [2:0][31:0] rdata, dout;
  logic [2:0][3:0] lvl;
  logic [1:0] lvl_a, lvl_b;
  logic [2:0] lvl_c;
  logic [31:0] base [3];
  logic [31:0] st [3];
  int h [3][3];
  int popped [3];
  int ridx [3];
  int tests = 0;
  int errs = 0;
`ifdef IPML_PREFETCH_ERR_CHK_EN
  logic [1:0] err_a, err_b, err_c;
`endif
  always #5 clk = ~clk;
  assign lvl[0] = {2'b00, lvl_a};
  assign lvl[1] = {2'b00, lvl_b};
  assign lvl[2] = {1'b0, lvl_c};

  ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .PF_DEPTH(2), .RAM_LAT(1)) u_a (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(empty[0]), .ram_rd_en(rd_en[0]), .ram_oce(oce[0]),
    .ram_rd_data(rdata[0]), .dout(dout[0]), .dout_valid(dv[0]), .dout_ready(ready[0]), .pf_level(lvl_a)
`ifdef IPML_PREFETCH_ERR_CHK_EN
    , .pf_err(err_a)
`endif
  );
  ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .PF_DEPTH(3), .RAM_LAT(2)) u_b (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(empty[1]), .ram_rd_en(rd_en[1]), .ram_oce(oce[1]),
    .ram_rd_data(rdata[1]), .dout(dout[1]), .dout_valid(dv[1]), .dout_ready(ready[1]), .pf_level(lvl_b)
`ifdef IPML_PREFETCH_ERR_CHK_EN
    , .pf_err(err_b)
`endif
  );
  ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .PF_DEPTH(4), .RAM_LAT(2)) u_c (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(empty[2]), .ram_rd_en(rd_en[2]), .ram_oce(oce[2]),
    .ram_rd_data(rdata[2]), .dout(dout[2]), .dout_valid(dv[2]), .dout_ready(ready[2]), .pf_level(lvl_c)
`ifdef IPML_PREFETCH_ERR_CHK_EN
    , .pf_err(err_c)
`endif
  );

  function automatic int dep(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 4;
  endfunction
  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction
  // words delivered by the RAM (issued LAT edges ago) minus words consumed
  function automatic int mlvl(input int i);
    return h[i][lat(i)] - popped[i];
  endfunction
  // a read may issue when words requested but not yet consumed (after this cycle's pop) leave room
  function automatic logic erd(input int i);
    int p;
    p = (mlvl(i) != 0 && ready[i]) ? 1 : 0;
    return !empty[i] && !rst && ((h[i][0] - popped[i] - p) < dep(i));
  endfunction

  // reference model: issue/deliver/consume counters plus an SDPRAM model returning base+address
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        h[i][0] <= 0;
        h[i][1] <= 0;
        h[i][2] <= 0;
        popped[i] <= 0;
        ridx[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        h[i][0] <= h[i][0] + int'(rd_en[i]);
        h[i][1] <= h[i][0];
        h[i][2] <= h[i][1];
        popped[i] <= popped[i] + ((mlvl(i) != 0 && ready[i]) ? 1 : 0);
        if (rd_en[i]) ridx[i] <= ridx[i] + 1;
        if (rd_en[i] && lat(i) == 1) rdata[i] <= base[i] + 32'(ridx[i]);
        if (rd_en[i] && lat(i) == 2) st[i] <= base[i] + 32'(ridx[i]);
        if (lat(i) == 2 && oce[i]) rdata[i] <= st[i];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    empty = 3'b111;
    ready = 3'b000;
    base[0] = 32'hA0;
    base[1] = 32'h1000;
    base[2] = 32'h2000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dv[i] !== 1'b0) begin errs++; $display("FAIL reset_valid[%0d] got %b want 0", i, dv[i]); end
      tests++;
      if (lvl[i] !== 4'd0) begin errs++; $display("FAIL reset_level[%0d] got %0d want 0", i, lvl[i]); end
      tests++;
      if (rd_en[i] !== 1'b0) begin errs++; $display("FAIL reset_rd_en[%0d] got %b want 0", i, rd_en[i]); end
      tests++;
      if (dout[i] !== 32'd0) begin errs++; $display("FAIL reset_dout[%0d] got %h want 0", i, dout[i]); end
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic_fill;
    int pulses, first, dvc;
    pulses = 0;
    first = -1;
    dvc = -1;
    empty[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (rd_en[0] !== erd(0)) begin errs++; $display("FAIL fill_rd_en c%0d got %b want %b", c, rd_en[0], erd(0)); end
      tests++;
      if (int'(lvl[0]) !== mlvl(0)) begin errs++; $display("FAIL fill_level c%0d got %0d want %0d", c, lvl[0], mlvl(0)); end
      if (rd_en[0] === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (dv[0] === 1'b1 && dvc < 0) dvc = c;
      tick();
    end
    @(negedge clk);
    tests++;
    if (pulses !== 2) begin errs++; $display("FAIL fill_pulses got %0d want 2", pulses); end
    tests++;
    if (dvc - first !== 2) begin errs++; $display("FAIL fill_latency got %0d want 2", dvc - first); end
    tests++;
    if (lvl[0] !== 4'd2) begin errs++; $display("FAIL fill_level_final got %0d want 2", lvl[0]); end
    tests++;
    if (dout[0] !== 32'hA0) begin errs++; $display("FAIL fill_dout got %h want a0", dout[0]); end
    tick();
  endtask

  task automatic test_streaming;
    int c, k, first_iss, first_pop, last_pop;
    logic prev_rd;
    c = 0;
    k = 0;
    first_iss = -1;
    first_pop = -1;
    last_pop = -1;
    prev_rd = 1'b0;
    ready[1] = 1'b1;
    empty[1] = 1'b0;
    while (k < 100 && c < 400) begin
      @(negedge clk);
      tests++;
      if (oce[1] !== prev_rd) begin errs++; $display("FAIL stream_oce c%0d got %b want %b", c, oce[1], prev_rd); end
      if (rd_en[1] === 1'b1 && first_iss < 0) first_iss = c;
      if (dv[1] === 1'b1) begin
        tests++;
        if (dout[1] !== 32'h1000 + 32'(k)) begin errs++; $display("FAIL stream_data k%0d got %h want %h", k, dout[1], 32'h1000 + 32'(k)); end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        k++;
      end
      prev_rd = rd_en[1];
      tick();
      if (h[1][0] >= 100) empty[1] = 1'b1;
      c++;
    end
    ready[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (k !== 100) begin errs++; $display("FAIL stream_count got %0d want 100", k); end
    tests++;
    if (first_pop - first_iss !== 3) begin errs++; $display("FAIL stream_first_latency got %0d want 3", first_pop - first_iss); end
    tests++;
    if (last_pop - first_pop !== 99) begin errs++; $display("FAIL stream_bubbles span got %0d want 99", last_pop - first_pop); end
    tests++;
    if (lvl[1] !== 4'd0) begin errs++; $display("FAIL stream_drained got %0d want 0", lvl[1]); end
    tick();
  endtask

  task automatic test_backpressure;
    int el;
    empty[2] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      el = mlvl(2);
      tests++;
      if (int'(lvl[2]) !== el) begin errs++; $display("FAIL bp_level c%0d got %0d want %0d", c, lvl[2], el); end
      tests++;
      if (lvl[2] > 4'd4) begin errs++; $display("FAIL bp_level_max c%0d got %0d want <=4", c, lvl[2]); end
      tests++;
      if (h[2][0] - popped[2] > 4) begin errs++; $display("FAIL bp_total c%0d got %0d want <=4", c, h[2][0] - popped[2]); end
      tests++;
      if (rd_en[2] !== erd(2)) begin errs++; $display("FAIL bp_rd_en c%0d got %b want %b", c, rd_en[2], erd(2)); end
      tests++;
      if (dv[2] !== (el != 0)) begin errs++; $display("FAIL bp_valid c%0d got %b want %b", c, dv[2], el != 0); end
      if (el != 0) begin
        tests++;
        if (dout[2] !== 32'h2000 + 32'(popped[2])) begin errs++; $display("FAIL bp_data c%0d got %h want %h", c, dout[2], 32'h2000 + 32'(popped[2])); end
      end
      tick();
      ready[2] = 1'($urandom_range(0, 1));
      empty[2] = ($urandom_range(0, 3) == 0);
    end
    empty[2] = 1'b1;
    ready[2] = 1'b1;
    repeat (12) tick();
    ready[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (dv[2] !== 1'b0) begin errs++; $display("FAIL bp_drain_valid got %b want 0", dv[2]); end
    tests++;
    if (popped[2] !== h[2][0]) begin errs++; $display("FAIL bp_lost_words consumed %0d want %0d", popped[2], h[2][0]); end
    tick();
  endtask

  task automatic test_empty_edge;
    int rise;
    rise = -1;
    empty[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_en[2] !== 1'b1) begin errs++; $display("FAIL edge_issue got %b want 1", rd_en[2]); end
    tick();
    empty[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (rd_en[2] !== 1'b0) begin errs++; $display("FAIL edge_no_issue c%0d got %b want 0", c, rd_en[2]); end
      if (dv[2] === 1'b1 && rise < 0) begin
        rise = c;
        tests++;
        if (dout[2] !== 32'h2000 + 32'(popped[2])) begin errs++; $display("FAIL edge_data got %h want %h", dout[2], 32'h2000 + 32'(popped[2])); end
      end
      tick();
    end
    @(negedge clk);
    tests++;
    if (rise !== 2) begin errs++; $display("FAIL edge_arrival cycle got %0d want 2", rise); end
    tests++;
    if (lvl[2] !== 4'd1) begin errs++; $display("FAIL edge_level got %0d want 1", lvl[2]); end
    tick();
    ready[2] = 1'b1;
    tick();
    ready[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (dv[2] !== 1'b0) begin errs++; $display("FAIL edge_valid_drop got %b want 0", dv[2]); end
    tick();
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clk);
    tests++;
    if (lvl[0] !== 4'd2) begin errs++; $display("FAIL rstmid_pre_level got %0d want 2", lvl[0]); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (dv[0] !== 1'b0) begin errs++; $display("FAIL rstmid_valid got %b want 0", dv[0]); end
    tests++;
    if (lvl[0] !== 4'd0) begin errs++; $display("FAIL rstmid_level got %0d want 0", lvl[0]); end
    tests++;
    if (rd_en[0] !== 1'b0) begin errs++; $display("FAIL rstmid_rd_en got %b want 0", rd_en[0]); end
    base[0] = 32'hB0;
    #2;
    rst = 1'b0;
    c = 0;
    while (lvl[0] !== 4'd2 && c < 10) begin
      tick();
      @(negedge clk);
      c++;
    end
    tests++;
    if (lvl[0] !== 4'd2) begin errs++; $display("FAIL rstmid_refill level got %0d want 2", lvl[0]); end
    tests++;
    if (dout[0] !== 32'hB0) begin errs++; $display("FAIL rstmid_refill_data got %h want b0", dout[0]); end
    tick();
  endtask

`ifdef IPML_PREFETCH_ERR_CHK_EN
  task automatic test_err;
    @(negedge clk);
    tests++;
    if (err_a !== 2'b00) begin errs++; $display("FAIL err_clean got %b want 00", err_a); end
    tests++;
    if (err_b[0] !== 1'b0 || err_c[0] !== 1'b0) begin errs++; $display("FAIL err_no_ovf got %b%b want 00", err_b[0], err_c[0]); end
    tick();
    empty[0] = 1'b1;
    ready[0] = 1'b1;
    repeat (5) tick();
    ready[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (err_a !== 2'b10) begin errs++; $display("FAIL err_underrun got %b want 10", err_a); end
    repeat (4) tick();
    @(negedge clk);
    tests++;
    if (err_a !== 2'b10) begin errs++; $display("FAIL err_sticky got %b want 10", err_a); end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    tests++;
    if (err_a !== 2'b00) begin errs++; $display("FAIL err_reset got %b want 00", err_a); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fill();
    test_streaming();
    test_backpressure();
    test_empty_edge();
    test_reset_mid();
`ifdef IPML_PREFETCH_ERR_CHK_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
